spiking_activation_array: RTL

Multi-channel integrate-and-fire activation stage for the spiking datapath: it takes a vector of per-channel input currents once per timestep and integrates them into signed membrane potentials. A channel spikes when its potential reaches the shared threshold. After a configurable number of timesteps, the stage presents saturating per-channel spike counts downstream. It sits between the accumulator array output and the next layer's input buffer, replacing single-channel threshold/accumulate pairs.

---
 rtl/spiking_activation_array_pkg.sv | 35 +++
 rtl/spiking_activation_array_if.sv | 34 +++
 rtl/spiking_activation_array_lif_channel.sv | 94 +++++++++
 rtl/spiking_activation_array.sv | 122 ++++++++++++
 4 files changed

// File: rtl/spiking_activation_array_pkg.sv
// Shared definitions for the spiking activation array.
//   - state_t      : FSM encoding (ST_INTEGRATE accepts timesteps, ST_OUTPUT presents counts)
//   - RST_ZERO / RST_SUBTRACT : post-spike membrane rule encodings
//   - sat_signed() : clamps a wide signed value into the signed range of a given width
package spiking_activation_array_pkg;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_OUTPUT    = 1'b1
  } state_t;

  localparam int RST_ZERO     = 0;
  localparam int RST_SUBTRACT = 1;

  // Working width of the saturate helper; callers sign-extend into it and
  // take the low bits of the result.
  localparam int SAT_WIDE = 64;

  function automatic logic signed [SAT_WIDE-1:0] sat_signed(
    input logic signed [SAT_WIDE-1:0] value,
    input int                         width
  );
    logic signed [SAT_WIDE-1:0] max_val;
    logic signed [SAT_WIDE-1:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (width - 1));
    if (value > max_val) begin
      return max_val;
    end else if (value < min_val) begin
      return min_val;
    end
    return value;
  endfunction

endpackage

// File: rtl/spiking_activation_array_if.sv
// Handshake/bus bundle of the spiking activation array.
//   master : producer/consumer side (drives currents, threshold, clear, out_ready)
//   slave  : the activation stage (drives in_ready, spikes, spike_valid, out_valid, counts)
// Channel i of in_current / spike_counts sits at [i*WIDTH +: WIDTH].
interface spiking_activation_array_if
  import spiking_activation_array_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 8
) ();

  logic                                  clear_state;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    in_current;
  logic [DATA_WIDTH-1:0]                 threshold;
  logic [NUM_CHANNELS-1:0]               spikes;
  logic                                  spike_valid;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]   spike_counts;

  modport master (
    output clear_state, in_valid, in_current, threshold, out_ready,
    input  in_ready, spikes, spike_valid, out_valid, spike_counts
  );

  modport slave (
    input  clear_state, in_valid, in_current, threshold, out_ready,
    output in_ready, spikes, spike_valid, out_valid, spike_counts
  );

endinterface

// File: rtl/spiking_activation_array_lif_channel.sv
// lif_channel: one leaky integrate-and-fire neuron.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : accept one timestep (integrate, fire, update)
//   clear      : zero membrane and count (wins over enable)
//   current    : signed input current for this timestep
//   threshold  : signed firing threshold
//   spike      : combinational fire decision for the current timestep
//   count      : saturating spike count
module lif_channel
  import spiking_activation_array_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8,
  parameter int RESET_MODE  = 0,
  parameter int LEAK_SHIFT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] current,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic                         spike,
  output logic [COUNT_WIDTH-1:0]       count
);

  // Two guard bits cover v - leak + cur and v_raw - threshold without overflow.
  localparam int WIDE = DATA_WIDTH + 2;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic signed [DATA_WIDTH-1:0] v_reg, v_next, v_raw;
  logic [COUNT_WIDTH-1:0]       count_reg, count_next;
  logic signed [WIDE-1:0]       v_ext, cur_ext, thr_ext, leak, v_sum, v_resid;
  logic signed [SAT_WIDE-1:0]   v_raw_sat, v_resid_sat;
  logic                         sat_unused;

  always_comb begin
    v_ext   = {{2{v_reg[DATA_WIDTH-1]}}, v_reg};
    cur_ext = {{2{current[DATA_WIDTH-1]}}, current};
    thr_ext = {{2{threshold[DATA_WIDTH-1]}}, threshold};

    // A zero shift would leave the full membrane as "leak", so 0 means no leak.
    if (LEAK_SHIFT == 0) begin
      leak = '0;
    end else begin
      leak = v_ext >>> LEAK_SHIFT;
    end

    v_sum     = v_ext - leak + cur_ext;
    v_raw_sat = sat_signed({{(SAT_WIDE-WIDE){v_sum[WIDE-1]}}, v_sum}, DATA_WIDTH);
    v_raw     = v_raw_sat[DATA_WIDTH-1:0];

    spike = (v_raw >= threshold);

    v_resid     = {{2{v_raw[DATA_WIDTH-1]}}, v_raw} - thr_ext;
    v_resid_sat = sat_signed({{(SAT_WIDE-WIDE){v_resid[WIDE-1]}}, v_resid}, DATA_WIDTH);

    v_next     = v_reg;
    count_next = count_reg;
    if (enable) begin
      if (spike) begin
        if (RESET_MODE == RST_SUBTRACT) begin
          v_next = v_resid_sat[DATA_WIDTH-1:0];
        end else begin
          v_next = '0;
        end
        if (count_reg != COUNT_MAX) begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end else begin
        v_next = v_raw;
      end
    end
  end

  // Upper bits of the saturate results are pure sign extension.
  assign sat_unused = ^{v_raw_sat[SAT_WIDE-1:DATA_WIDTH], v_resid_sat[SAT_WIDE-1:DATA_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else if (clear) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/spiking_activation_array.sv
// spiking_activation_array: multi-channel integrate-and-fire activation stage.
// Integrates one current vector per accepted timestep; after TIMESTEPS accepts
// it presents per-channel saturating spike counts until the downstream takes them.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of spiking_activation_array_if
//              (clear_state, in_valid/in_ready/in_current/threshold,
//               spikes/spike_valid, out_valid/out_ready/spike_counts)
module spiking_activation_array
  import spiking_activation_array_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 8,
  parameter int TIMESTEPS    = 8,
  parameter int RESET_MODE   = 0,
  parameter int LEAK_SHIFT   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  spiking_activation_array_if.slave  bus
);

  localparam int T_W = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMESTEPS - 1);

  state_t                              state_reg, state_next;
  logic [T_W-1:0]                      t_reg, t_next;
  logic                                in_ready_int;
  logic                                out_valid_int;
  logic                                accept;
  logic                                out_fire;
  logic                                chan_clear;
  logic [NUM_CHANNELS-1:0]             spike_vec;
  logic [NUM_CHANNELS-1:0]             spikes_reg;
  logic                                spike_valid_reg;
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] counts_flat;

  // Handshake readiness comes only from the state register.
  assign in_ready_int  = (state_reg == ST_INTEGRATE);
  assign out_valid_int = (state_reg == ST_OUTPUT);

  // An input coinciding with clear_state is dropped.
  assign accept     = bus.in_valid && in_ready_int && !bus.clear_state;
  assign out_fire   = out_valid_int && bus.out_ready;
  assign chan_clear = bus.clear_state || out_fire;

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    if (bus.clear_state) begin
      state_next = ST_INTEGRATE;
      t_next     = '0;
    end else begin
      case (state_reg)
        ST_INTEGRATE: begin
          if (accept) begin
            if (t_reg == T_LAST) begin
              t_next     = '0;
              state_next = ST_OUTPUT;
            end else begin
              t_next = t_reg + T_W'(1);
            end
          end
        end
        ST_OUTPUT: begin
          if (out_fire) begin
            state_next = ST_INTEGRATE;
          end
        end
        default: state_next = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_INTEGRATE;
      t_reg           <= '0;
      spikes_reg      <= '0;
      spike_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      if (bus.clear_state) begin
        spikes_reg      <= '0;
        spike_valid_reg <= 1'b0;
      end else begin
        spike_valid_reg <= accept;
        if (accept) begin
          spikes_reg <= spike_vec;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      lif_channel #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .RESET_MODE  (RESET_MODE),
        .LEAK_SHIFT  (LEAK_SHIFT)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .enable    (accept),
        .clear     (chan_clear),
        .current   (bus.in_current[gi*DATA_WIDTH +: DATA_WIDTH]),
        .threshold (bus.threshold),
        .spike     (spike_vec[gi]),
        .count     (counts_flat[gi*COUNT_WIDTH +: COUNT_WIDTH])
      );
    end
  endgenerate

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = out_valid_int;
  assign bus.spikes       = spikes_reg;
  assign bus.spike_valid  = spike_valid_reg;
  assign bus.spike_counts = counts_flat;

endmodule
